rs_class_dispatch: RTL and testbench
====================================

// Module: rs_class_dispatch
// PURPOSE
//   Parametrised dispatch front-end for N reservation-station classes (ALU, MEM, MUL, ...). It sits between rename and the
//   per-class RS arrays, and adds per-class credit flow control: a full class stalls only its own instructions, not every
//   dispatch. It also merges the per-class FU results onto the single CDB through a round-robin arbiter with a registered output.
// PARAMETERS
//   NUM_CLASSES  2    number of RS classes / FU result channels (>=2)
//   RS_DEPTH     8    entries per class RS; initial credit value
//   TAG_W        5    ROB tag width
//   DATA_W       32   result value width
//   PAYLOAD_W    128  opaque dispatch bundle (control, src vals/addrs, dst, imm, pc)
//   localparams  CLASS_W=$clog2(NUM_CLASSES), CNT_W=$clog2(RS_DEPTH+1)
// PORTS
//   clk           in   1                   clock, all state on rising edge
//   reset         in   1                   asynchronous, active-high
//   flush         in   1                   synchronous pipeline flush
//   disp_valid    in   1                   new renamed instruction offered
//   disp_class    in   CLASS_W             target RS class
//   disp_tag      in   TAG_W               ROB tag of instruction
//   disp_payload  in   PAYLOAD_W           instruction bundle
//   disp_ready    out  1                   hold register can accept this cycle
//   rs_valid      out  NUM_CLASSES         one-hot write strobe into class RS
//   rs_tag        out  TAG_W               tag to RS (shared bus)
//   rs_payload    out  PAYLOAD_W           bundle to RS (shared bus)
//   rs_release    in   NUM_CLASSES         per-class pulse: one RS entry freed
//   class_full    out  NUM_CLASSES         credit[c]==0
//   credit_cnt    out  NUM_CLASSES*CNT_W   free entries per class, class c at [c*CNT_W +: CNT_W]
//   fu_res_valid  in   NUM_CLASSES         FU result pending per class
//   fu_res_tag    in   NUM_CLASSES*TAG_W   per-class result tag
//   fu_res_data   in   NUM_CLASSES*DATA_W  per-class result value
//   fu_res_ready  out  NUM_CLASSES         one-hot grant; result consumed this cycle
//   cdb_valid     out  1                   CDB broadcast valid
//   cdb_tag       out  TAG_W               CDB tag
//   cdb_data      out  DATA_W              CDB value
//   cdb_ready     in   1                   CDB consumers accept broadcast
//   err           out  1                   sticky: credit overflow or illegal class
// BEHAVIOUR
//   Reset values: hold/cdb regs invalid, rs_valid=0, fu_res_ready=0, cdb_valid/tag/data=0, credits=RS_DEPTH, rr_ptr=0, err=0.
//   Hold register (1 entry): issue = hold_v & (credit[hold_class]!=0). rs_valid[hold_class]=issue. rs_valid is driven combinationally from registered state.
//   disp_ready = !hold_v | issue. On disp_valid&disp_ready, load the hold register. Latency from accept to rs_valid is 1 cycle minimum.
//   Back-to-back dispatch to a class with credit gives 1 instruction/cycle. A blocked head stalls later dispatches (in order) and does not reorder.
//   disp_class>=NUM_CLASSES: accept, drop (no rs_valid), set err.
//   Credits: credit[c] next = credit[c] - issue_c + rs_release[c]. Simultaneous issue and release leaves the count unchanged.
//   A release when credit==RS_DEPTH (and no issue): saturate at RS_DEPTH and set err. Credit never underflows, because issue requires !=0.
//   CDB arbiter: load when !cdb_valid | cdb_ready. Grant g = first c with fu_res_valid starting at rr_ptr, wrapping mod NUM_CLASSES.
//   On grant: fu_res_ready[g]=1 (combinational, same cycle), load {tag,data}[g] into the CDB regs, cdb_valid=1 next cycle, rr_ptr <= (g+1) mod NUM_CLASSES.
//   With no request, cdb_valid clears if it was consumed, and rr_ptr holds.
//   Stall: cdb_valid & !cdb_ready holds tag/data stable, fu_res_ready=0, and rr_ptr is unchanged.
//   Throughput: 1 broadcast/cycle when cdb_ready is held high. Every requester is granted within NUM_CLASSES loads.
//   Flush (priority over all except reset): next cycle hold_v=0, cdb_valid=0, credits=RS_DEPTH, rr_ptr=0.
//   During the flush cycle, rs_valid and fu_res_ready are forced 0, and disp input and rs_release are ignored. err is cleared only by reset.
//   Reset asserted mid-operation clears all state asynchronously. Outputs reach reset values immediately.
// TESTING
//   T1 reset: assert reset mid-traffic -> credit_cnt all 8, cdb_valid=0, disp_ready=1, err=0 with no clock edge.
//   T2 per-class stall: 8 dispatches to class 1, no release -> class_full[1]=1 and the 9th class-1 op holds.
//      A class-0 op behind it waits until rs_release[1] pulses, then issues the following cycle.
//   T3 same-cycle issue+release on class 0 at credit=3 -> credit stays 3; rs_valid=2'b01 for exactly 1 cycle.
//   T4 round-robin: fu_res_valid=2'b11 held, cdb_ready=1 -> cdb_tag alternates class0, class1, class0 each cycle.
//      cdb_ready=0 for 2 cycles -> cdb_tag/data stable and fu_res_ready=0.
//   T5 errors: rs_release[0] at credit=8 -> credit stays 8, err=1 and stays set across flush.
//      With NUM_CLASSES=3, disp_class=3 is dropped with err=1.
//   T6 flush with hold_v=1, credit[0]=2, cdb_valid=1 -> next cycle hold_v=0, cdb_valid=0, credit[0]=8, and no rs_valid pulse occurs.

Source files
------------

// File: rtl/rs_class_dispatch.sv
// rs_class_dispatch: credit-gated dispatch into per-class reservation stations,
// plus a round-robin merge of per-class FU results onto one registered CDB.
module rs_class_dispatch #(
    parameter int NUM_CLASSES = 2,
    parameter int RS_DEPTH    = 8,
    parameter int TAG_W       = 5,
    parameter int DATA_W      = 32,
    parameter int PAYLOAD_W   = 128,
    localparam int CLASS_W    = $clog2(NUM_CLASSES),
    localparam int CNT_W      = $clog2(RS_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          disp_valid,
    input  logic [CLASS_W-1:0]            disp_class,
    input  logic [TAG_W-1:0]              disp_tag,
    input  logic [PAYLOAD_W-1:0]          disp_payload,
    output logic                          disp_ready,
    output logic [NUM_CLASSES-1:0]        rs_valid,
    output logic [TAG_W-1:0]              rs_tag,
    output logic [PAYLOAD_W-1:0]          rs_payload,
    input  logic [NUM_CLASSES-1:0]        rs_release,
    output logic [NUM_CLASSES-1:0]        class_full,
    output logic [NUM_CLASSES*CNT_W-1:0]  credit_cnt,
    input  logic [NUM_CLASSES-1:0]        fu_res_valid,
    input  logic [NUM_CLASSES*TAG_W-1:0]  fu_res_tag,
    input  logic [NUM_CLASSES*DATA_W-1:0] fu_res_data,
    output logic [NUM_CLASSES-1:0]        fu_res_ready,
    output logic                          cdb_valid,
    output logic [TAG_W-1:0]              cdb_tag,
    output logic [DATA_W-1:0]             cdb_data,
    input  logic                          cdb_ready,
    output logic                          err
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RS_DEPTH);

    logic                   hold_v;
    logic [CLASS_W-1:0]     hold_class;
    logic [TAG_W-1:0]       hold_tag;
    logic [PAYLOAD_W-1:0]   hold_payload;
    logic [CNT_W-1:0]       credit [NUM_CLASSES];
    logic [CLASS_W-1:0]     rr_ptr, gnt, idx;
    logic                   gnt_v, issue, cdb_load, disp_fire, bad_class, overflow;
    logic [NUM_CLASSES-1:0] hold_dec, at_max;

    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            class_full[c] = credit[c] == '0;
            at_max[c] = credit[c] == FULL;
            credit_cnt[c*CNT_W +: CNT_W] = credit[c];
        end
    end

    assign hold_dec   = NUM_CLASSES'(1) << hold_class;
    assign issue      = hold_v & |(hold_dec & ~class_full) & ~flush;
    assign rs_valid   = issue ? hold_dec : '0;
    assign rs_tag     = hold_tag;
    assign rs_payload = hold_payload;
    assign disp_ready = ~hold_v | issue;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign bad_class  = 32'(disp_class) >= NUM_CLASSES;
    // A release that would push a class past its depth is a protocol error.
    assign overflow   = |(rs_release & ~rs_valid & at_max) & ~flush;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_v = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
            idx = CLASS_W'((int'(rr_ptr) + i) % NUM_CLASSES);
            if (fu_res_valid[idx]) begin
                gnt_v = 1'b1;
                gnt = idx;
            end
        end
    end

    assign cdb_load     = ~cdb_valid | cdb_ready;
    assign fu_res_ready = (gnt_v & cdb_load & ~flush & ~reset) ? NUM_CLASSES'(1) << gnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_v <= 1'b0;
            hold_class <= '0;
            hold_tag <= '0;
            hold_payload <= '0;
            cdb_valid <= 1'b0;
            cdb_tag <= '0;
            cdb_data <= '0;
            rr_ptr <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) credit[c] <= FULL;
        end else if (flush) begin
            hold_v <= 1'b0;
            cdb_valid <= 1'b0;
            rr_ptr <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) credit[c] <= FULL;
        end else begin
            if (disp_fire) begin
                hold_v <= ~bad_class;
                hold_class <= disp_class;
                hold_tag <= disp_tag;
                hold_payload <= disp_payload;
            end else if (issue) begin
                hold_v <= 1'b0;
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (rs_valid[c] & ~rs_release[c])
                    credit[c] <= credit[c] - CNT_W'(1);
                else if (rs_release[c] & ~rs_valid[c] & ~at_max[c])
                    credit[c] <= credit[c] + CNT_W'(1);
            end
            if (cdb_load) begin
                cdb_valid <= gnt_v;
                if (gnt_v) begin
                    cdb_tag <= fu_res_tag[gnt*TAG_W +: TAG_W];
                    cdb_data <= fu_res_data[gnt*DATA_W +: DATA_W];
                    rr_ptr <= (gnt == CLASS_W'(NUM_CLASSES - 1)) ? '0 : gnt + CLASS_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if ((disp_fire & bad_class) | overflow)
            err <= 1'b1;
    end
endmodule

// File: tb/tb_rs_class_dispatch.sv
// tb_rs_class_dispatch: table-driven CDB arbitration vectors, directed corner
// sequences and randomized traffic checked against a behavioural model.
module tb_rs_class_dispatch;
    localparam int N = 2, D = 8, TW = 5, DW = 32, PW = 128;

    logic            clk = 0, reset = 1, flush = 0, disp_valid = 0, cdb_ready = 0;
    logic [0:0]      disp_class = '0;
    logic [TW-1:0]   disp_tag = '0;
    logic [PW-1:0]   disp_payload = '0;
    logic [N-1:0]    rs_release = '0, fu_res_valid = '0;
    logic [N*TW-1:0] fu_res_tag = '0;
    logic [N*DW-1:0] fu_res_data = '0;
    logic            disp_ready, cdb_valid, err;
    logic [N-1:0]    rs_valid, class_full, fu_res_ready;
    logic [TW-1:0]   rs_tag, cdb_tag;
    logic [PW-1:0]   rs_payload;
    logic [N*4-1:0]  credit_cnt;
    logic [DW-1:0]   cdb_data;

    logic            d3_flush = 0, d3_disp_valid = 0, d3_cdb_ready = 1;
    logic [1:0]      d3_disp_class = '0;
    logic [TW-1:0]   d3_disp_tag = '0;
    logic [PW-1:0]   d3_disp_payload = '0;
    logic [2:0]      d3_rs_release = '0, d3_fu_res_valid = '0;
    logic [3*TW-1:0] d3_fu_res_tag = '0;
    logic [3*DW-1:0] d3_fu_res_data = '0;
    logic            d3_disp_ready, d3_cdb_valid, d3_err;
    logic [2:0]      d3_rs_valid, d3_class_full, d3_fu_res_ready;
    logic [TW-1:0]   d3_rs_tag, d3_cdb_tag;
    logic [PW-1:0]   d3_rs_payload;
    logic [11:0]     d3_credit_cnt;
    logic [DW-1:0]   d3_cdb_data;

    rs_class_dispatch #(.NUM_CLASSES(N), .RS_DEPTH(D), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .disp_valid(disp_valid), .disp_class(disp_class),
        .disp_tag(disp_tag), .disp_payload(disp_payload), .disp_ready(disp_ready), .rs_valid(rs_valid),
        .rs_tag(rs_tag), .rs_payload(rs_payload), .rs_release(rs_release), .class_full(class_full),
        .credit_cnt(credit_cnt), .fu_res_valid(fu_res_valid), .fu_res_tag(fu_res_tag),
        .fu_res_data(fu_res_data), .fu_res_ready(fu_res_ready), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ready(cdb_ready), .err(err));

    rs_class_dispatch #(.NUM_CLASSES(3), .RS_DEPTH(D), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW)) dut3 (
        .clk(clk), .reset(reset), .flush(d3_flush), .disp_valid(d3_disp_valid), .disp_class(d3_disp_class),
        .disp_tag(d3_disp_tag), .disp_payload(d3_disp_payload), .disp_ready(d3_disp_ready),
        .rs_valid(d3_rs_valid), .rs_tag(d3_rs_tag), .rs_payload(d3_rs_payload), .rs_release(d3_rs_release),
        .class_full(d3_class_full), .credit_cnt(d3_credit_cnt), .fu_res_valid(d3_fu_res_valid),
        .fu_res_tag(d3_fu_res_tag), .fu_res_data(d3_fu_res_data), .fu_res_ready(d3_fu_res_ready),
        .cdb_valid(d3_cdb_valid), .cdb_tag(d3_cdb_tag), .cdb_data(d3_cdb_data),
        .cdb_ready(d3_cdb_ready), .err(d3_err));

    always #5 clk = ~clk;

    int vec = 0, bad = 0;

    // Behavioural model: a one-deep hold slot, integer credits, a CDB slot.
    bit             m_hv, m_cv, m_err;
    int             m_hc, m_rr;
    int             m_cr[N];
    logic [TW-1:0]  m_ht, m_ct;
    logic [PW-1:0]  m_hp;
    logic [DW-1:0]  m_cd;

    typedef struct {
        logic [1:0]    fv;
        logic          rdy;
        logic [1:0]    fr;
        logic          cv;
        logic [TW-1:0] tag;
    } rr_vec_t;
    rr_vec_t tbl[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_hv = 0; m_cv = 0; m_err = 0; m_hc = 0; m_rr = 0;
        m_ht = '0; m_ct = '0; m_hp = '0; m_cd = '0;
        for (int c = 0; c < N; c++) m_cr[c] = D;
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; rs_release = '0; fu_res_valid = '0; cdb_ready = 1;
    endtask

    // Inputs are set by the caller just after a clock edge; compare, advance model, clock.
    task automatic cyc();
        bit iss, ld, fnd;
        int g;
        logic [N-1:0] erv, efr, efull;
        logic [N*4-1:0] ecc;
        #1;
        iss = m_hv && m_cr[m_hc] > 0 && !flush;
        erv = iss ? N'(1 << m_hc) : '0;
        fnd = 0;
        g = 0;
        for (int i = 0; i < N; i++)
            if (!fnd && fu_res_valid[(m_rr + i) % N]) begin
                fnd = 1;
                g = (m_rr + i) % N;
            end
        ld = !m_cv || cdb_ready;
        efr = (fnd && ld && !flush) ? N'(1 << g) : '0;
        for (int c = 0; c < N; c++) begin
            ecc[c*4 +: 4] = 4'(m_cr[c]);
            efull[c] = m_cr[c] == 0;
        end
        chk("disp_ready", disp_ready, !m_hv || iss);
        chk("rs_valid", rs_valid, erv);
        if (iss) begin
            chk("rs_tag", rs_tag, m_ht);
            chk("rs_payload", rs_payload, m_hp);
        end
        chk("fu_res_ready", fu_res_ready, efr);
        chk("cdb_valid", cdb_valid, m_cv);
        if (m_cv) begin
            chk("cdb_tag", cdb_tag, m_ct);
            chk("cdb_data", cdb_data, m_cd);
        end
        chk("credit_cnt", credit_cnt, ecc);
        chk("class_full", class_full, efull);
        chk("err", err, m_err);
        if (flush) begin
            m_hv = 0; m_cv = 0; m_rr = 0;
            for (int c = 0; c < N; c++) m_cr[c] = D;
        end else begin
            for (int c = 0; c < N; c++)
                if (erv[c] && !rs_release[c]) m_cr[c]--;
                else if (!erv[c] && rs_release[c]) begin
                    if (m_cr[c] == D) m_err = 1;
                    else m_cr[c]++;
                end
            if (disp_valid && (!m_hv || iss)) begin
                if (int'(disp_class) >= N) begin
                    m_err = 1;
                    m_hv = 0;
                end else begin
                    m_hv = 1; m_hc = int'(disp_class); m_ht = disp_tag; m_hp = disp_payload;
                end
            end else if (iss) m_hv = 0;
            if (ld) begin
                m_cv = fnd;
                if (fnd) begin
                    m_ct = fu_res_tag[g*TW +: TW];
                    m_cd = fu_res_data[g*DW +: DW];
                    m_rr = (g + 1) % N;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b0, 5'h00};
        tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1, 5'h0A};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1, 5'h0B};
        tbl[3]  = '{2'b11, 1'b0, 2'b00, 1'b1, 5'h0A};
        tbl[4]  = '{2'b11, 1'b0, 2'b00, 1'b1, 5'h0A};
        tbl[5]  = '{2'b11, 1'b1, 2'b10, 1'b1, 5'h0A};
        tbl[6]  = '{2'b00, 1'b0, 2'b00, 1'b1, 5'h0B};
        tbl[7]  = '{2'b00, 1'b1, 2'b00, 1'b1, 5'h0B};
        tbl[8]  = '{2'b10, 1'b0, 2'b10, 1'b0, 5'h00};
        tbl[9]  = '{2'b01, 1'b1, 2'b01, 1'b1, 5'h0B};
        tbl[10] = '{2'b00, 1'b1, 2'b00, 1'b1, 5'h0A};
        tbl[11] = '{2'b00, 1'b1, 2'b00, 1'b0, 5'h00};

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_credit", credit_cnt, 8'h88);
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_err", err, 0);
        reset = 0;
        m_reset();

        // Three-class instance: an out-of-range class is accepted, dropped, and flagged.
        d3_disp_valid = 1; d3_disp_class = 2'd3; d3_disp_tag = 5'd7;
        #1 chk("d3_ready", d3_disp_ready, 1);
        @(posedge clk); #1;
        d3_disp_class = 2'd2; d3_disp_tag = 5'd9;
        #1 chk("d3_drop", d3_rs_valid, 3'b000);
        chk("d3_err", d3_err, 1);
        @(posedge clk); #1;
        d3_disp_valid = 0;
        #1 chk("d3_issue2", d3_rs_valid, 3'b100);
        chk("d3_tag", d3_rs_tag, 5'd9);
        @(posedge clk); #1;

        // Round-robin CDB vectors.
        fu_res_tag = {5'h0B, 5'h0A};
        fu_res_data = {32'hB0B0, 32'hA0A0};
        for (int i = 0; i < 12; i++) begin
            fu_res_valid = tbl[i].fv;
            cdb_ready = tbl[i].rdy;
            #1;
            chk("rr_grant", fu_res_ready, tbl[i].fr);
            chk("rr_valid", cdb_valid, tbl[i].cv);
            if (tbl[i].cv) chk("rr_tag", cdb_tag, tbl[i].tag);
            cyc();
        end

        // Per-class stall: nine class-1 ops, then a class-0 op stuck behind them.
        idle(); flush = 1; cyc();
        for (int i = 0; i < 9; i++) begin
            idle(); disp_valid = 1; disp_class = 1'b1; disp_tag = 5'(i);
            disp_payload = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        idle(); disp_valid = 1; disp_class = 1'b0; disp_tag = 5'h1F;
        #1 chk("t2_full", class_full[1], 1);
        chk("t2_stall", disp_ready, 0);
        cyc();
        cyc();
        rs_release = 2'b10;
        cyc();
        rs_release = 2'b00;
        #1 chk("t2_resume", rs_valid, 2'b10);
        cyc();
        disp_valid = 0;
        #1 chk("t2_class0", rs_valid, 2'b01);
        chk("t2_class0_tag", rs_tag, 5'h1F);
        cyc();

        // Same-cycle issue and release at credit 3.
        idle(); flush = 1; cyc();
        for (int i = 0; i < 6; i++) begin
            idle(); disp_valid = 1; disp_class = 1'b0; disp_tag = 5'(i + 1);
            cyc();
        end
        idle(); rs_release = 2'b01;
        #1 chk("t3_issue", rs_valid, 2'b01);
        chk("t3_credit_pre", credit_cnt[3:0], 3);
        cyc();
        idle();
        #1 chk("t3_credit", credit_cnt[3:0], 3);
        chk("t3_once", rs_valid, 2'b00);
        cyc();

        // Flush with a held op, credit 2 and a valid CDB.
        idle(); disp_valid = 1; disp_class = 1'b0; disp_tag = 5'h11; cyc();
        idle(); disp_valid = 1; disp_class = 1'b0; disp_tag = 5'h12;
        fu_res_valid = 2'b01; cdb_ready = 0; cyc();
        idle(); flush = 1; cdb_ready = 0;
        #1 chk("t6_cdb_pre", cdb_valid, 1);
        chk("t6_credit_pre", credit_cnt[3:0], 2);
        chk("t6_no_rs", rs_valid, 2'b00);
        cyc();
        idle();
        #1 chk("t6_cdb", cdb_valid, 0);
        chk("t6_credit", credit_cnt, 8'h88);
        chk("t6_hold", disp_ready, 1);
        chk("t6_no_rs_after", rs_valid, 2'b00);
        cyc();

        // Release at full credit saturates and sets a sticky error.
        idle(); rs_release = 2'b01; cyc();
        idle();
        #1 chk("t5_err", err, 1);
        chk("t5_sat", credit_cnt[3:0], 8);
        flush = 1; cyc();
        idle();
        #1 chk("t5_sticky", err, 1);
        cyc();

        // Randomized traffic, with an asynchronous reset mid-stream.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                fu_res_valid = 2'b11;
                reset = 1;
                #1 chk("t1_credit", credit_cnt, 8'h88);
                chk("t1_cdb_valid", cdb_valid, 0);
                chk("t1_disp_ready", disp_ready, 1);
                chk("t1_err", err, 0);
                chk("t1_rs_valid", rs_valid, 2'b00);
                chk("t1_fu_ready", fu_res_ready, 2'b00);
                m_reset();
                @(posedge clk); #1;
                reset = 0;
            end
            flush = ($urandom % 40) == 0;
            disp_valid = ($urandom % 4) != 0;
            disp_class = 1'($urandom);
            disp_tag = 5'($urandom);
            disp_payload = {$urandom, $urandom, $urandom, $urandom};
            for (int c = 0; c < N; c++)
                rs_release[c] = ($urandom % 3 == 0) && (m_cr[c] < D || $urandom % 20 == 0);
            fu_res_valid = 2'($urandom);
            fu_res_tag = 10'($urandom);
            fu_res_data = {$urandom, $urandom};
            cdb_ready = ($urandom % 4) != 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
